pc_fetch_sequencer: RTL

PC_FETCH_SEQUENCER -- requirements
Module: pc_fetch_sequencer

---
 rtl/pc_fetch_pkg.sv | 23 ++
 rtl/pc_next_sel.sv | 22 ++
 rtl/pc_fetch_sequencer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC fetch sequencer and its next-PC mux.
package pc_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] ALIGN_MASK       = 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_HALTED
  } state_e;

  typedef enum logic [1:0] {
    NPC_HOLD,
    NPC_SEQ,
    NPC_BRANCH,
    NPC_PENDING
  } npc_sel_e;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC select: hold, sequential step, word-aligned branch target, or pending target.
module pc_next_sel
  import pc_fetch_pkg::*;
(
  input  npc_sel_e    sel,
  input  logic [31:0] pc,
  input  logic [31:0] branch_target,
  input  logic [31:0] pending_pc,
  output logic [31:0] next_pc
);

  always_comb begin
    next_pc = pc;
    unique case (sel)
      NPC_SEQ:     next_pc = pc + PC_STEP;
      NPC_BRANCH:  next_pc = branch_target & ALIGN_MASK;
      NPC_PENDING: next_pc = pending_pc;
      default:     next_pc = pc;
    endcase
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch/issue sequencer: one outstanding imem request, one issued instruction at a time.
// Optional branch delay slot behaviour is enabled by defining PC_FETCH_DELAY_SLOT_EN.
module pc_fetch_sequencer
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Halt,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemAck,
  input  logic [31:0] ImemData,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  output logic [31:0] PCPlus4,
  output logic        Halted
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] pend_pc;
  npc_sel_e    npc_sel;
  logic        handshake;

`ifdef PC_FETCH_DELAY_SLOT_EN
  logic [31:0] pend_q, pend_d;
  logic        ds_q, ds_d;
  assign pend_pc = pend_q;
`else
  assign pend_pc = '0;
`endif

  assign handshake = (state_q == S_ISSUE) && !Stall;

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    npc_sel    = NPC_HOLD;
`ifdef PC_FETCH_DELAY_SLOT_EN
    pend_d     = pend_q;
    ds_d       = ds_q;
`endif
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH, S_WAIT: begin
        state_d = S_WAIT;
        if (ImemAck) begin
          instr_d    = ImemData;
          instr_pc_d = pc_q;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (handshake) begin
          state_d = S_FETCH;
          if (Halt) begin
            // Halt wins over any redirect; a pending delay-slot target is dropped.
            state_d = S_HALTED;
`ifdef PC_FETCH_DELAY_SLOT_EN
            ds_d    = 1'b0;
`endif
          end else begin
`ifdef PC_FETCH_DELAY_SLOT_EN
            if (ds_q) begin
              npc_sel = NPC_PENDING;
              ds_d    = 1'b0;
            end else if (BranchTaken) begin
              npc_sel = NPC_SEQ;
              pend_d  = BranchTarget & ALIGN_MASK;
              ds_d    = 1'b1;
            end else begin
              npc_sel = NPC_SEQ;
            end
`else
            npc_sel = BranchTaken ? NPC_BRANCH : NPC_SEQ;
`endif
          end
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  pc_next_sel u_next_sel (
    .sel          (npc_sel),
    .pc           (pc_q),
    .branch_target(BranchTarget),
    .pending_pc   (pend_pc),
    .next_pc      (pc_d)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= RESET_PC;
`ifdef PC_FETCH_DELAY_SLOT_EN
      pend_q     <= '0;
      ds_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
`ifdef PC_FETCH_DELAY_SLOT_EN
      pend_q     <= pend_d;
      ds_q       <= ds_d;
`endif
    end
  end

  assign ImemReq    = (state_q == S_FETCH) || (state_q == S_WAIT);
  assign ImemAddr   = pc_q;
  assign InstrValid = (state_q == S_ISSUE);
  assign Instr      = instr_q;
  assign InstrPC    = instr_pc_q;
  assign PCPlus4    = instr_pc_q + PC_STEP;
  assign Halted     = (state_q == S_HALTED);

endmodule
